// File: rtl/avalon_pkg.sv
// Shared Avalon-MM initiator types.
// Command bundle and port FSM state encoding.
package avalon_pkg;

  localparam int AVM_ADDR_W = 32;
  localparam int AVM_DATA_W = 32;
  localparam int AVM_BE_W   = AVM_DATA_W / 8;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } avm_state_t;

  typedef struct packed {
    logic                  write;
    logic [AVM_ADDR_W-1:0] address;
    logic [AVM_DATA_W-1:0] writedata;
    logic [AVM_BE_W-1:0]   byteenable;
  } avm_cmd_t;

endpackage

// File: rtl/avalon_master_port_resp_fifo.sv
// Read-response FIFO for the Avalon initiator.
// Head word is held in a register so dout never comes from a mux.
module resp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic [AW-1:0]    w_rptr_nx;
  logic [CW-1:0]    w_cnt_nx;
  logic [WIDTH-1:0] w_head_nx;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_dout  = r_dout;
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Next head: bypass the incoming word when it lands at the new head.
  always_comb begin
    w_rptr_nx = r_rptr + AW'(w_pop);
    w_cnt_nx  = r_cnt + CW'(w_push) - CW'(w_pop);
    w_head_nx = r_mem[w_rptr_nx];
    if (w_cnt_nx == '0)
      w_head_nx = '0;
    else if (w_push && (r_wptr == w_rptr_nx))
      w_head_nx = i_din;
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_dout <= '0;
    end else begin
      r_wptr <= r_wptr + AW'(w_push);
      r_rptr <= w_rptr_nx;
      r_cnt  <= w_cnt_nx;
      r_dout <= w_head_nx;
    end
  end

  a_no_overflow: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && o_full)
  );

endmodule

// File: rtl/avalon_master_port.sv
// Avalon-MM initiator: valid/ready commands in, Avalon transfers out.
// Read data returns in issue order through a credit-limited FIFO.
module avalon_master_port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_RD = 4
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_address,
  input  logic [DATA_W-1:0]   cmd_writedata,
  input  logic [DATA_W/8-1:0] cmd_byteenable,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_readdata,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic                busy
);

  import avalon_pkg::*;

  localparam int BE_W = DATA_W / 8;
  localparam int CRW  = $clog2(MAX_RD) + 1;

  avm_state_t        r_state;
  logic [CRW-1:0]    r_credit;
  logic              r_read;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;

  logic w_accept;
  logic w_done;
  logic w_rd_acc;
  logic w_pop;
  logic w_credit_ok;
  logic w_empty;
  logic w_full;

  assign w_credit_ok = (r_credit < CRW'(MAX_RD));
  assign w_done      = (r_state == REQ) && !avm_waitrequest;
  assign cmd_ready   = resetn
                    && ((r_state == IDLE) || !avm_waitrequest)
                    && (cmd_write || w_credit_ok);
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_rd_acc    = w_accept && !cmd_write;
  assign w_pop       = rsp_valid && rsp_ready;

  assign avm_read       = r_read;
  assign avm_write      = r_write;
  assign avm_address    = r_addr;
  assign avm_writedata  = r_wdata;
  assign avm_byteenable = r_be;
  assign rsp_valid      = !w_empty;
  assign busy = (r_state == REQ) || (r_credit != '0) || !w_empty;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_accept) begin
      r_state <= REQ;
      r_read  <= !cmd_write;
      r_write <= cmd_write;
      r_addr  <= cmd_address;
      r_wdata <= cmd_writedata;
      r_be    <= cmd_byteenable;
    end else if (w_done) begin
      r_state <= IDLE;
      r_read  <= 1'b0;
      r_write <= 1'b0;
    end
  end

  // Credit covers reads in flight on the fabric plus words in the FIFO.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_credit <= '0;
    end else begin
      unique case (1'b1)
        (w_rd_acc && !w_pop): r_credit <= r_credit + CRW'(1);
        (w_pop && !w_rd_acc): r_credit <= r_credit - CRW'(1);
        default: ;
      endcase
    end
  end

  resp_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (MAX_RD)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (resetn),
    .i_push  (avm_readdatavalid),
    .i_din   (avm_readdata),
    .i_pop   (rsp_ready),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_dout  (rsp_readdata)
  );

  a_full_credit: assert property (
    @(posedge clock) disable iff (!resetn)
    w_full |-> (r_credit == CRW'(MAX_RD))
  );

endmodule

// File: tb/tb_avalon_master_port.sv
// Bench for avalon_master_port: directed scenarios plus a
// randomized run against a queue-based transaction model.
module tb_avalon_master_port;

  import avalon_pkg::*;

  localparam int MAX_RD = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_address;
  logic [31:0] cmd_writedata;
  logic [3:0]  cmd_byteenable;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_readdata;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int lat = 1;
  logic [31:0] smem [16];
  logic [31:0] got [$];

  logic        sv [4];
  logic [31:0] sd [4];
  logic        s_fire;
  logic [31:0] s_data;

  always #5 clock = ~clock;

  avalon_master_port #(
    .ADDR_W (32),
    .DATA_W (32),
    .MAX_RD (MAX_RD)
  ) dut (
    .clock             (clock),
    .resetn            (resetn),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_write         (cmd_write),
    .cmd_address       (cmd_address),
    .cmd_writedata     (cmd_writedata),
    .cmd_byteenable    (cmd_byteenable),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_readdata      (rsp_readdata),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .busy              (busy)
  );

  // Slave: returns smem[word] 'lat' cycles after a completed read.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        sv[i] = 1'b0;
        sd[i] = '0;
      end
      avm_readdatavalid = 1'b0;
      avm_readdata = '0;
    end else begin
      s_fire = avm_read && !avm_waitrequest;
      s_data = smem[avm_address[5:2]];
      for (int i = 0; i < 3; i++) begin
        sv[i] = sv[i+1];
        sd[i] = sd[i+1];
      end
      sv[3] = 1'b0;
      sv[lat-1] = s_fire;
      sd[lat-1] = s_data;
      #1;
      avm_readdatavalid = sv[0];
      avm_readdata = sd[0];
    end
  end

  task automatic idle_in();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_address = '0;
    cmd_writedata = '0;
    cmd_byteenable = '0;
  endtask

  task automatic drain(output int ok);
    ok = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      idle_in();
      avm_waitrequest = 1'b0;
      rsp_ready = 1'b1;
      #1;
      if (rsp_valid) got.push_back(rsp_readdata);
      if (!busy && !rsp_valid) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    idle_in();
    rsp_ready = 1'b0;
    avm_waitrequest = 1'b0;
    #1 resetn = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if ({avm_read, avm_write, cmd_ready, rsp_valid, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got rd/wr/rdy/rv/busy=%b exp 00000",
        {avm_read, avm_write, cmd_ready, rsp_valid, busy});
    end
    checks++;
    if ({avm_address, avm_writedata, avm_byteenable, rsp_readdata} !== '0) begin
      errors++;
      $display("FAIL reset_data got a=%h wd=%h be=%h rd=%h exp 0",
        avm_address, avm_writedata, avm_byteenable, rsp_readdata);
    end
    @(negedge clock);
    resetn = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release got rdy/busy=%b exp 10", {cmd_ready, busy});
    end
  endtask

  task automatic test_write();
    int nwr, first, rseen, ok;
    logic [31:0] wa, wdat;
    logic [3:0] wb;
    nwr = 0; first = -1; rseen = 0;
    wa = '0; wdat = '0; wb = '0;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_address = 32'h4; cmd_writedata = 32'hDEAD_BEEF;
    cmd_byteenable = 4'hF;
    avm_waitrequest = 1'b0; rsp_ready = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL write_ready got %b exp 1", cmd_ready);
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      idle_in();
      #1;
      if (avm_write) begin
        if (first < 0) begin
          first = c; wa = avm_address; wdat = avm_writedata; wb = avm_byteenable;
        end
        nwr++;
      end
      if (rsp_valid) rseen = 1;
    end
    checks++;
    if (nwr !== 1 || first !== 1) begin
      errors++;
      $display("FAIL write_pulse got cycles=%0d first=%0d exp 1 at 1", nwr, first);
    end
    checks++;
    if ({wa, wdat, wb} !== {32'h4, 32'hDEAD_BEEF, 4'hF}) begin
      errors++;
      $display("FAIL write_fields got a=%h d=%h be=%h exp 4 deadbeef f", wa, wdat, wb);
    end
    checks++;
    if (rseen !== 0) begin
      errors++;
      $display("FAIL write_no_rsp got rsp_valid seen exp never");
    end
    drain(ok);
  endtask

  task automatic test_latency();
    int first, ok;
    logic [31:0] d;
    lat = 1; first = -1; d = '0;
    smem[5] = $urandom;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 32'h14;
    avm_waitrequest = 1'b0; rsp_ready = 1'b1;
    #1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      idle_in();
      #1;
      if (rsp_valid && first < 0) begin
        first = c; d = rsp_readdata;
      end
    end
    checks++;
    if (first !== 3 || d !== smem[5]) begin
      errors++;
      $display("FAIL read_latency got cycle=%0d data=%h exp cycle=3 data=%h",
        first, d, smem[5]);
    end
    drain(ok);
  endtask

  task automatic test_wait();
    int nrd, stable, rdy_ok, ok;
    lat = 1; nrd = 0; stable = 1; rdy_ok = 1;
    smem[0] = $urandom;
    got.delete();
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 32'h0;
    avm_waitrequest = 1'b0; rsp_ready = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      idle_in();
      avm_waitrequest = (k < 3);
      #1;
      if (avm_read) begin
        nrd++;
        if (avm_address !== 32'h0) stable = 0;
      end
      if (k < 3 && cmd_ready !== 1'b0) rdy_ok = 0;
      if (k == 3 && cmd_ready !== 1'b1) rdy_ok = 0;
    end
    checks++;
    if (nrd !== 4 || stable !== 1) begin
      errors++;
      $display("FAIL wait_hold got cycles=%0d stable=%0d exp 4 1", nrd, stable);
    end
    checks++;
    if (rdy_ok !== 1) begin
      errors++;
      $display("FAIL wait_ready got ok=%0d exp 1", rdy_ok);
    end
    drain(ok);
    checks++;
    if (ok !== 1 || got.size() !== 1 || got[0] !== smem[0]) begin
      errors++;
      $display("FAIL wait_data got n=%0d exp 1 word %h", got.size(), smem[0]);
    end
  endtask

  task automatic test_pipelined();
    int rd_ok, ok;
    logic exp_rd;
    logic [31:0] expv [4];
    lat = 2; rd_ok = 1;
    expv[0] = 32'h11; expv[1] = 32'h22; expv[2] = 32'h33; expv[3] = 32'h44;
    for (int i = 0; i < 4; i++) smem[i] = expv[i];
    got.delete();
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      if (c < 4) begin
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 32'(c * 4);
      end else begin
        idle_in();
      end
      avm_waitrequest = 1'b0; rsp_ready = 1'b1;
      #1;
      if (c < 4 && cmd_ready !== 1'b1) rd_ok = 0;
      exp_rd = (c >= 1 && c <= 4);
      if (avm_read !== exp_rd) rd_ok = 0;
      if (exp_rd && avm_address !== 32'((c - 1) * 4)) rd_ok = 0;
      if (rsp_valid) got.push_back(rsp_readdata);
    end
    drain(ok);
    checks++;
    if (rd_ok !== 1) begin
      errors++;
      $display("FAIL pipe_issue got ok=%0d exp 1", rd_ok);
    end
    checks++;
    if (got.size() !== 4 || got[0] !== expv[0] || got[1] !== expv[1] ||
        got[2] !== expv[2] || got[3] !== expv[3]) begin
      errors++;
      $display("FAIL pipe_order got n=%0d exp 11 22 33 44", got.size());
    end
  endtask

  task automatic test_credit();
    int nacc, ok, dok;
    logic [31:0] wd;
    lat = 1; nacc = 0;
    got.delete();
    for (int i = 0; i < 8; i++) smem[i] = $urandom;
    rsp_ready = 1'b0; avm_waitrequest = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      cmd_valid = 1'b1; cmd_write = 1'b0;
      cmd_address = 32'(nacc * 4); cmd_byteenable = 4'hF;
      #1;
      if (cmd_ready) nacc++;
    end
    checks++;
    if (nacc !== 4 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL credit_stall got acc=%0d rdy=%b exp 4 0", nacc, cmd_ready);
    end
    @(negedge clock);
    wd = $urandom;
    cmd_write = 1'b1; cmd_address = 32'h100; cmd_writedata = wd;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL credit_write_ok got %b exp 1", cmd_ready);
    end
    @(negedge clock);
    cmd_write = 1'b0; cmd_address = 32'(nacc * 4);
    #1;
    checks++;
    if ({avm_write, avm_address, avm_writedata} !== {1'b1, 32'h100, wd}) begin
      errors++;
      $display("FAIL credit_write_issue got w=%b a=%h d=%h exp 1 100 %h",
        avm_write, avm_address, avm_writedata, wd);
    end
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL credit_full got %b exp 0", cmd_ready);
    end
    @(negedge clock);
    rsp_ready = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b10) begin
      errors++;
      $display("FAIL credit_pop got rv/rdy=%b exp 10", {rsp_valid, cmd_ready});
    end
    if (rsp_valid) got.push_back(rsp_readdata);
    @(negedge clock);
    rsp_ready = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL credit_reopen got %b exp 1", cmd_ready);
    end
    if (cmd_ready) nacc++;
    @(negedge clock);
    cmd_address = 32'(nacc * 4);
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL credit_restall got %b exp 0", cmd_ready);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      rsp_ready = 1'b1; cmd_address = 32'(nacc * 4);
      #1;
      if (rsp_valid) got.push_back(rsp_readdata);
      if (cmd_ready) begin
        nacc++;
        break;
      end
    end
    drain(ok);
    dok = (got.size() == 6);
    for (int i = 0; i < 6 && dok == 1; i++)
      if (got[i] !== smem[i]) dok = 0;
    checks++;
    if (ok !== 1 || nacc !== 6 || dok !== 1) begin
      errors++;
      $display("FAIL credit_data got acc=%0d n=%0d ok=%0d exp 6 6 1",
        nacc, got.size(), dok);
    end
  endtask

  task automatic test_pushpop();
    int nacc, ok, dok;
    lat = 1; nacc = 0;
    got.delete();
    for (int i = 0; i < 8; i++) smem[i] = $urandom;
    rsp_ready = 1'b0; avm_waitrequest = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 32'(c * 4);
      #1;
      if (cmd_ready) nacc++;
    end
    @(negedge clock);
    idle_in();
    #1;
    @(negedge clock);
    rsp_ready = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, avm_readdatavalid} !== 2'b11 || nacc !== 3) begin
      errors++;
      $display("FAIL pp_setup got rv/rdv=%b acc=%0d exp 11 3",
        {rsp_valid, avm_readdatavalid}, nacc);
    end
    if (rsp_valid) got.push_back(rsp_readdata);
    nacc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      rsp_ready = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 32'((3 + nacc) * 4);
      #1;
      if (cmd_ready) nacc++;
    end
    checks++;
    if (nacc !== 2) begin
      errors++;
      $display("FAIL pp_credit got acc=%0d exp 2", nacc);
    end
    drain(ok);
    dok = (got.size() == 5);
    for (int i = 0; i < 5 && dok == 1; i++)
      if (got[i] !== smem[i]) dok = 0;
    checks++;
    if (ok !== 1 || dok !== 1) begin
      errors++;
      $display("FAIL pp_data got n=%0d ok=%0d exp 5 1", got.size(), dok);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] wd;
    lat = 1;
    smem[9] = $urandom;
    rsp_ready = 1'b0; avm_waitrequest = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 32'h24;
    #1;
    repeat (2) begin
      @(negedge clock);
      idle_in();
      #1;
    end
    @(negedge clock);
    wd = $urandom;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 32'h80;
    cmd_writedata = wd; cmd_byteenable = 4'h0;
    avm_waitrequest = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b11) begin
      errors++;
      $display("FAIL rm_setup got rv/rdy=%b exp 11", {rsp_valid, cmd_ready});
    end
    @(negedge clock);
    idle_in();
    #1;
    checks++;
    if ({avm_write, avm_address, avm_writedata, avm_byteenable} !==
        {1'b1, 32'h80, wd, 4'h0}) begin
      errors++;
      $display("FAIL rm_zero_be got w=%b a=%h d=%h be=%h exp 1 80 %h 0",
        avm_write, avm_address, avm_writedata, avm_byteenable, wd);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({avm_read, avm_write, avm_address, avm_writedata, avm_byteenable,
         rsp_valid, busy} !== '0) begin
      errors++;
      $display("FAIL rm_async got r=%b w=%b a=%h d=%h be=%h rv=%b busy=%b exp 0",
        avm_read, avm_write, avm_address, avm_writedata, avm_byteenable,
        rsp_valid, busy);
    end
    @(negedge clock);
    resetn = 1'b1;
    avm_waitrequest = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
      errors++;
      $display("FAIL rm_release got rdy/busy/rv=%b exp 100",
        {cmd_ready, busy, rsp_valid});
    end
  endtask

  task automatic test_random();
    avm_cmd_t pend [$];
    logic [31:0] exp_rd [$];
    avm_cmd_t cur;
    int outst, ok;
    logic exp_ready, exp_busy, exp_pres;
    lat = 2; outst = 0;
    for (int i = 0; i < 16; i++) smem[i] = $urandom;
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      if (c < 500) begin
        cmd_valid = ($urandom_range(0, 2) != 0);
        cmd_write = ($urandom_range(0, 2) == 0);
        cmd_address = 32'($urandom_range(0, 15)) << 2;
        cmd_writedata = $urandom;
        cmd_byteenable = 4'($urandom);
        avm_waitrequest = ($urandom_range(0, 3) == 0);
        rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        idle_in();
        avm_waitrequest = 1'b0;
        rsp_ready = 1'b1;
      end
      #1;
      exp_pres = (pend.size() != 0);
      exp_ready = (!exp_pres || !avm_waitrequest) &&
                  (cmd_write || outst < MAX_RD);
      exp_busy = exp_pres || (outst > 0);
      checks++;
      if (cmd_ready !== exp_ready) begin
        errors++;
        $display("FAIL rnd_ready c=%0d got %b exp %b", c, cmd_ready, exp_ready);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL rnd_busy c=%0d got %b exp %b", c, busy, exp_busy);
      end
      checks++;
      if ((avm_read || avm_write) !== exp_pres) begin
        errors++;
        $display("FAIL rnd_present c=%0d got %b exp %b",
          c, avm_read || avm_write, exp_pres);
      end
      if (exp_pres) begin
        cur = pend[0];
        checks++;
        if ({avm_write, avm_read, avm_address, avm_byteenable} !==
            {cur.write, !cur.write, cur.address, cur.byteenable} ||
            (cur.write && avm_writedata !== cur.writedata)) begin
          errors++;
          $display("FAIL rnd_xfer c=%0d got w=%b a=%h d=%h be=%h exp w=%b a=%h d=%h be=%h",
            c, avm_write, avm_address, avm_writedata, avm_byteenable,
            cur.write, cur.address, cur.writedata, cur.byteenable);
        end
        if (!avm_waitrequest) void'(pend.pop_front());
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_rd.size() == 0) begin
          errors++;
          $display("FAIL rnd_rsp c=%0d got %h exp none", c, rsp_readdata);
        end else begin
          if (rsp_readdata !== exp_rd[0]) begin
            errors++;
            $display("FAIL rnd_rsp c=%0d got %h exp %h", c, rsp_readdata, exp_rd[0]);
          end
          void'(exp_rd.pop_front());
          outst--;
        end
      end
      if (cmd_valid && cmd_ready) begin
        pend.push_back('{cmd_write, cmd_address, cmd_writedata, cmd_byteenable});
        if (!cmd_write) begin
          exp_rd.push_back(smem[cmd_address[5:2]]);
          outst++;
        end
      end
    end
    got.delete();
    drain(ok);
    checks++;
    if (ok !== 1 || pend.size() !== 0 || exp_rd.size() !== 0 || got.size() !== 0) begin
      errors++;
      $display("FAIL rnd_drain got ok=%0d pend=%0d rd=%0d extra=%0d exp 1 0 0 0",
        ok, pend.size(), exp_rd.size(), got.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout exp finish before 100us");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_latency();
    test_wait();
    test_pipelined();
    test_credit();
    test_pushpop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
